// File: rtl/riscv_uart_rx_if.sv
// riscv_uart_rx_if: received-byte valid/ready stream plus receiver status
interface riscv_uart_rx_if;
  logic [7:0] dOut;
  logic       dOutValid;
  logic       dOutReady;
  logic       framingErr;
  logic       overrun;
  logic       busy;
  modport master(output dOut, dOutValid, framingErr, overrun, busy, input dOutReady);
  modport slave(input dOut, dOutValid, framingErr, overrun, busy, output dOutReady);
endinterface

// File: rtl/riscv_uart_rx.sv
// riscv_uart_rx: 8N1 UART receiver with mid-bit sampling and a one-byte holding register (optional RISCV_URX_GLITCH_FILTER_EN)
module riscv_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 57600
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_i,
  riscv_uart_rx_if.master bus_o
);
  localparam int COUNT = CLK_FREQ / BAUD;
  localparam int HALF  = COUNT / 2;
  localparam int W     = $clog2(COUNT) + 1;
  localparam logic [W-1:0] CNT_BIT  = W'(COUNT - 1);
  localparam logic [W-1:0] CNT_HALF = W'(HALF - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t       state_q, state_d;
  logic [1:0]   sync_q;
  logic         rx_s, rx_l, rx_p_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   sh_q, sh_d, dout_q, dout_d;
  logic         vld_q, vld_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic         done, load;
  assign rx_s = sync_q[1];
`ifdef RISCV_URX_GLITCH_FILTER_EN
  logic [2:0] flt_q;
  // last three synchronized samples feed a majority vote
  always_ff @(posedge clk) flt_q <= !rstn ? 3'b111 : {flt_q[1:0], rx_s};
  assign rx_l = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
  assign rx_l = rx_s;
`endif
  // state, counters, line history and holding register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      rx_p_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      rx_p_q  <= rx_l;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  // frame sequencing: start detect, mid-bit sampling, stop check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (rx_p_q && !rx_l) begin
        state_d = START;
        cnt_d   = CNT_HALF;
      end
      START: if (cnt_q == '0) begin
        state_d = rx_l ? IDLE : DATA;
        cnt_d   = CNT_BIT;
        idx_d   = '0;
      end else cnt_d = cnt_q - 1'b1;
      DATA: if (cnt_q == '0) begin
        sh_d    = {rx_l, sh_q[7:1]};
        cnt_d   = CNT_BIT;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end else cnt_d = cnt_q - 1'b1;
      default: if (cnt_q == '0) begin
        state_d = IDLE;
        done    = rx_l;
        ferr_d  = !rx_l;
      end else cnt_d = cnt_q - 1'b1;
    endcase
  end
  // holding register: accept when empty or being drained, otherwise flag overrun
  always_comb begin
    load   = done && (!vld_q || bus_o.dOutReady);
    dout_d = load ? sh_q : dout_q;
    vld_d  = done || (vld_q && !bus_o.dOutReady);
    ovr_d  = done && vld_q && !bus_o.dOutReady;
  end
  assign bus_o.dOut       = dout_q;
  assign bus_o.dOutValid  = vld_q;
  assign bus_o.framingErr = ferr_q;
  assign bus_o.overrun    = ovr_q;
  assign bus_o.busy       = state_q != IDLE;
endmodule

// File: tb/tb_riscv_uart_rx.sv
// tb_riscv_uart_rx: scoreboard bench for the UART receiver at 10 clocks per bit
module tb_riscv_uart_rx;
  localparam logic [1:0] K_BYTE = 2'd0, K_FERR = 2'd1, K_OVR = 2'd2;
  typedef struct {logic [1:0] kind; logic [7:0] data;} ev_t;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1;
  int checks = 0, errors = 0, vld_hi = 0;
  logic seen;
  ev_t sb[$];
  riscv_uart_rx_if bus();
  riscv_uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rstn(rstn), .rx_i(rx), .bus_o(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask
  task automatic observe(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none", k, d);
    end else begin
      e = sb.pop_front();
      check("event_kind", {6'd0, k}, {6'd0, e.kind});
      if (e.kind == K_BYTE && k == K_BYTE) check("dOut", d, e.data);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (10) @(negedge clk);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.dOutValid) vld_hi++;
      if (rstn && bus.dOutValid && bus.dOutReady) observe(K_BYTE, bus.dOut);
      if (bus.framingErr) observe(K_FERR, 8'h00);
      if (bus.overrun) observe(K_OVR, 8'h00);
    end
  end
  initial begin
    bus.dOutReady = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_dOut", bus.dOut, 8'h00);
    check("rst_valid", {7'd0, bus.dOutValid}, 8'd0);
    check("rst_ferr", {7'd0, bus.framingErr}, 8'd0);
    check("rst_ovr", {7'd0, bus.overrun}, 8'd0);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    bus.dOutReady = 1'b1;
    vld_hi = 0;
    push(K_BYTE, 8'h55);
    send(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check("valid_cycles_55", vld_hi[7:0], 8'd1);
    bus.dOutReady = 1'b0;
    push(K_OVR, 8'h00);
    push(K_BYTE, 8'hA3);
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check("ovr_hold_dOut", bus.dOut, 8'hA3);
    check("ovr_hold_valid", {7'd0, bus.dOutValid}, 8'd1);
    @(negedge clk);
    bus.dOutReady = 1'b1;
    @(negedge clk);
    bus.dOutReady = 1'b0;
    #1;
    check("valid_cleared", {7'd0, bus.dOutValid}, 8'd0);
    repeat (5) @(negedge clk);
    push(K_BYTE, 8'hC4);
    push(K_BYTE, 8'h7E);
    send(8'hC4, 1'b1);
    repeat (5) @(negedge clk);
    fork
      send(8'h7E, 1'b1);
      begin
        repeat (97) @(negedge clk);
        bus.dOutReady = 1'b1;
        @(negedge clk);
        bus.dOutReady = 1'b0;
        #1;
        check("same_cycle_dOut", bus.dOut, 8'h7E);
        check("same_cycle_valid", {7'd0, bus.dOutValid}, 8'd1);
        check("same_cycle_ovr", {7'd0, bus.overrun}, 8'd0);
      end
    join
    repeat (3) @(negedge clk);
    bus.dOutReady = 1'b1;
    repeat (3) @(negedge clk);
    push(K_FERR, 8'h00);
    send(8'h81, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1 seen |= bus.busy;
    end
    check("break_busy", {7'd0, seen}, 8'd0);
    check("ferr_valid", {7'd0, bus.dOutValid}, 8'd0);
    rx = 1'b1;
    repeat (15) @(negedge clk);
    push(K_BYTE, 8'h5A);
    send(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rx = 1'b1;
      #1 seen |= bus.busy;
    end
    check("false_start_busy", {7'd0, seen}, 8'd1);
    check("false_start_idle", {7'd0, bus.busy}, 8'd0);
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) rx = 1'b1;
      #1 seen |= bus.busy;
    end
`ifdef RISCV_URX_GLITCH_FILTER_EN
    check("glitch_busy", {7'd0, seen}, 8'd0);
`else
    check("glitch_busy", {7'd0, seen}, 8'd1);
`endif
    bus.dOutReady = 1'b0;
    send(8'h96, 1'b1);
    repeat (3) @(negedge clk);
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (55) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("midrst_dOut", bus.dOut, 8'h00);
        check("midrst_valid", {7'd0, bus.dOutValid}, 8'd0);
        check("midrst_busy", {7'd0, bus.busy}, 8'd0);
        check("midrst_ferr", {7'd0, bus.framingErr}, 8'd0);
        check("midrst_ovr", {7'd0, bus.overrun}, 8'd0);
      end
    join
    bus.dOutReady = 1'b1;
    repeat (5) @(negedge clk);
    push(K_BYTE, 8'h3C);
    send(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size() > 255 ? 8'hFF : 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
